// File: rtl/inv_firstround.sv
`default_nettype none
// ============================================================================
// inv_firstround : first decrypt step -- AddRoundKey(ROUND), InvShiftRows,
//                  byte-serial InvSubBytes through one shared inverse S-box.
// Revision 1.0
// ============================================================================
module inv_firstround #(
    parameter int ROUND = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1407:0]  key,
    input  logic [127:0]   state,
    input  logic           start,
    output logic [127:0]   out,
    output logic           finish
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ISR  = 2'd1;
    localparam logic [1:0] S_SUB  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // FIPS-197 InvSbox, entry 0x00 in the MSBs.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] wreg_q, wreg_d;
    logic [127:0] out_q, out_d;
    logic         finish_q, finish_d;
    logic [127:0] w_round_key;
    logic [7:0]   w_sub_in;
    logic [7:0]   w_sub_out;

    assign w_round_key = key[1407-128*ROUND -: 128];

    // Column-major bytes: s(r,c) is byte 4*c+r; row r is rotated right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    always_comb begin
        w_sub_in = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (cnt_q == i[3:0]) begin
                w_sub_in = wreg_q[127-8*i -: 8];
            end
        end
    end

    assign w_sub_out = INV_SBOX[11'd2047 - {w_sub_in, 3'b000} -: 8];

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        wreg_d   = wreg_q;
        out_d    = out_q;
        finish_d = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                if (start) begin
                    wreg_d = state ^ w_round_key;
                    fsm_d  = S_ISR;
                end
            end
            S_ISR: begin
                wreg_d = inv_shift_rows(wreg_q);
                cnt_d  = 4'd0;
                fsm_d  = S_SUB;
            end
            S_SUB: begin
                for (int i = 0; i < 16; i++) begin
                    if (cnt_q == i[3:0]) begin
                        wreg_d[127-8*i -: 8] = w_sub_out;
                    end
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                out_d    = wreg_q;
                finish_d = 1'b1;
                fsm_d    = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            cnt_q    <= 4'd0;
            wreg_q   <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            wreg_q   <= wreg_d;
            out_q    <= out_d;
            finish_q <= finish_d;
        end
    end

    assign out    = out_q;
    assign finish = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_inv_firstround.sv
`default_nettype none
// ============================================================================
// tb_inv_firstround : scoreboard bench for inv_firstround.
// Revision 1.0
// ============================================================================
module tb_inv_firstround;

    logic           clk = 1'b0;
    logic           rst;
    logic [1407:0]  key;
    logic [127:0]   state;
    logic           start;
    logic [127:0]   out;
    logic           finish;

    int             n_vec = 0;
    int             n_err = 0;
    logic [7:0]     isb [256];
    logic [127:0]   exp_q [$];

    always #5 clk = ~clk;

    inv_firstround #(.ROUND(10)) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .state  (state),
        .start  (start),
        .out    (out),
        .finish (finish)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from GF(2^8) inverse plus affine map; inverted into isb.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [1407:0] k);
        logic [127:0] a;
        logic [127:0] r;
        a = st ^ k[1407-128*10 -: 128];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127-8*(4*c+rr) -: 8] = isb[a[127-8*(4*((c-rr+4)%4)+rr) -: 8]];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [1407:0] rand_key();
        logic [1407:0] k;
        for (int i = 0; i < 44; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 128'hx;
        return exp_q.pop_front();
    endfunction

    // Launch one block and watch for `window` edges; cyc numbers edges after T.
    task automatic run_block(input logic [127:0] st, input logic [1407:0] k,
                             input bit scramble, input bit pulses, input int window,
                             output int lat, output int nfin,
                             output logic [127:0] got, output logic [127:0] mid);
        lat  = -1;
        nfin = 0;
        got  = '0;
        mid  = '0;
        @(negedge clk);
        state = st;
        key   = k;
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= window; cyc++) begin
            @(negedge clk);
            start = pulses && (cyc == 5 || cyc == 10);
            if (scramble) begin
                state = rand128();
                key   = rand_key();
            end
            @(posedge clk);
            #1;
            if (cyc == 10) mid = out;
            if (finish) begin
                nfin++;
                if (lat < 0) begin
                    lat = cyc;
                    got = out;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        state = '0;
        key   = '0;
        #2;
        n_vec++;
        if (out !== 128'h0) begin n_err++; $display("FAIL reset_out: got %h want 0", out); end
        n_vec++;
        if (finish !== 1'b0) begin n_err++; $display("FAIL reset_finish: got %b want 0", finish); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (finish !== 1'b0) begin n_err++; $display("FAIL idle_finish: got %b want 0", finish); end
    endtask

    task automatic test_fips();
        logic [127:0] st, got, mid;
        logic [1407:0] k;
        int lat, nfin;
        st = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        k  = rand_key();
        k[127:0] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        exp_q.push_back(model(st, k));
        run_block(st, k, 1'b0, 1'b0, 25, lat, nfin, got, mid);
        n_vec++;
        if (got !== pop_exp()) begin n_err++; $display("FAIL fips_scoreboard: got %h", got); end
        // After ARK, InvShiftRows and InvSubBytes (FIPS-197 C.1 round[1].is_box).
        n_vec++;
        if (got !== 128'hbd6e7c3df2b5779e0b61216e8b10b689) begin
            n_err++; $display("FAIL fips_out: got %h want bd6e7c3df2b5779e0b61216e8b10b689", got);
        end
        n_vec++;
        if (lat != 18) begin n_err++; $display("FAIL fips_latency: got %0d want 18", lat); end
        n_vec++;
        if (nfin != 1) begin n_err++; $display("FAIL fips_finish_count: got %0d want 1", nfin); end
    endtask

    task automatic test_zero();
        logic [127:0] got, mid;
        int lat, nfin;
        exp_q.push_back(model('0, '0));
        run_block('0, '0, 1'b0, 1'b0, 25, lat, nfin, got, mid);
        n_vec++;
        if (got !== pop_exp()) begin n_err++; $display("FAIL zero_scoreboard: got %h", got); end
        n_vec++;
        if (got !== {16{8'h52}}) begin n_err++; $display("FAIL zero_out: got %h want 5252..52", got); end
        n_vec++;
        if (nfin != 1) begin n_err++; $display("FAIL zero_finish_width: got %0d cycles want 1", nfin); end
    endtask

    task automatic test_busy();
        logic [127:0] st, got, mid, prev;
        logic [1407:0] k;
        int lat, nfin;
        prev = out;
        st = rand128();
        k  = rand_key();
        exp_q.push_back(model(st, k));
        run_block(st, k, 1'b0, 1'b1, 40, lat, nfin, got, mid);
        n_vec++;
        if (got !== pop_exp()) begin n_err++; $display("FAIL busy_out: got %h", got); end
        n_vec++;
        if (nfin != 1) begin n_err++; $display("FAIL busy_finish_count: got %0d want 1", nfin); end
        n_vec++;
        if (lat != 18) begin n_err++; $display("FAIL busy_latency: got %0d want 18", lat); end
        n_vec++;
        if (mid !== prev) begin n_err++; $display("FAIL out_hold: got %h want %h", mid, prev); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] st, got, mid;
        logic [1407:0] k;
        int lat, nfin, late_fin;
        @(negedge clk);
        state = rand128();
        key   = rand_key();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out !== 128'h0) begin n_err++; $display("FAIL midreset_out: got %h want 0", out); end
        n_vec++;
        if (finish !== 1'b0) begin n_err++; $display("FAIL midreset_finish: got %b want 0", finish); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        late_fin = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (finish) late_fin++;
        end
        n_vec++;
        if (late_fin != 0) begin n_err++; $display("FAIL aborted_finish: got %0d pulses want 0", late_fin); end
        st = rand128();
        k  = rand_key();
        exp_q.push_back(model(st, k));
        run_block(st, k, 1'b0, 1'b0, 20, lat, nfin, got, mid);
        n_vec++;
        if (got !== pop_exp()) begin n_err++; $display("FAIL post_reset_out: got %h", got); end
        n_vec++;
        if (lat != 18) begin n_err++; $display("FAIL post_reset_latency: got %0d want 18", lat); end
    endtask

    task automatic test_sample_hold();
        logic [127:0] st, got, mid;
        logic [1407:0] k;
        int lat, nfin;
        for (int n = 0; n < 3; n++) begin
            st = rand128();
            k  = rand_key();
            exp_q.push_back(model(st, k));
            run_block(st, k, 1'b1, 1'b0, 20, lat, nfin, got, mid);
            n_vec++;
            if (got !== pop_exp()) begin n_err++; $display("FAIL sample_hold_out[%0d]: got %h", n, got); end
            n_vec++;
            if (lat != 18) begin n_err++; $display("FAIL sample_hold_latency[%0d]: got %0d want 18", n, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] s1, s2, e;
        logic [1407:0] k1, k2;
        int t [$];
        s1 = rand128(); k1 = rand_key();
        s2 = rand128(); k2 = rand_key();
        exp_q.push_back(model(s1, k1));
        exp_q.push_back(model(s2, k2));
        @(negedge clk);
        state = s1;
        key   = k1;
        start = 1'b1;
        @(posedge clk);
        #1;
        state = s2;
        key   = k2;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (cyc == 20) start = 1'b0;
            @(posedge clk);
            #1;
            if (finish) begin
                t.push_back(cyc);
                e = pop_exp();
                n_vec++;
                if (out !== e) begin n_err++; $display("FAIL b2b_out@%0d: got %h want %h", cyc, out, e); end
            end
        end
        start = 1'b0;
        n_vec++;
        if (t.size() != 2) begin
            n_err++; $display("FAIL b2b_count: got %0d finishes want 2", t.size());
        end else begin
            n_vec++;
            if (t[0] != 18 || t[1] != 37) begin
                n_err++; $display("FAIL b2b_timing: got %0d,%0d want 18,37", t[0], t[1]);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_sweep();
        logic [127:0] st, got, mid, e;
        int lat, nfin;
        for (int v = 0; v < 256; v++) begin
            st = {8'(v), 120'h0};
            exp_q.push_back(model(st, '0));
            run_block(st, '0, 1'b0, 1'b0, 18, lat, nfin, got, mid);
            e = pop_exp();
            n_vec++;
            if (got !== e) begin n_err++; $display("FAIL sweep_model[%02h]: got %h want %h", v, got, e); end
            n_vec++;
            if (got[127:120] !== isb[v] || got[119:0] !== {15{8'h52}}) begin
                n_err++; $display("FAIL sweep_bytes[%02h]: got %h want byte0 %h rest 52", v, got, isb[v]);
            end
        end
    endtask

    initial begin
        for (int x = 0; x < 256; x++) isb[fwd_sbox(8'(x))] = 8'(x);
        test_reset();
        test_fips();
        test_zero();
        test_busy();
        test_reset_mid();
        test_sample_hold();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
